wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- in-order writeback arbiter for a register file.
//
// Each instruction that writes rd is issued with a one-hot result-source
// select and a destination index.  The entry travels through PIPE_DEPTH
// stages; when it reaches the head stage it waits for its selected source
// to present a valid result, then the result is written to the register
// file one cycle later.  While the head waits, the whole pipe freezes and
// upstream is told to hold issue via o_stall.
//
// Optional feature macro: WB_ARBITER_BYPASS_EN
//   When defined, o_byp_valid / o_byp_waddr / o_byp_wdata expose the write
//   that o_rd_* will present after the next rising edge (operand forwarding).
//
// Ports:
//   clk            sole clock, rising edge
//   rstn           asynchronous active-low reset
//   i_issue_valid  instruction with an rd write issued this cycle
//   i_issue_sel    one-hot result-source select (NUM_SRC bits)
//   i_issue_waddr  destination register index
//   o_stall        head is waiting on its source; upstream must hold issue
//   i_src_valid    per-source result valid (NUM_SRC bits)
//   i_src_data     flattened source results, source k at [k*XLEN +: XLEN]
//   o_sel_err      one-cycle pulse when a multi-hot select retires at head
//   o_rd_wvalid    register file write strobe
//   o_rd_waddr     register file write index
//   o_rd_wdata     register file write data
//   o_byp_*        (WB_ARBITER_BYPASS_EN only) next-edge write preview
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_issue_valid,
  input  logic [NUM_SRC-1:0]      i_issue_sel,
  input  logic [4:0]              i_issue_waddr,
  output logic                    o_stall,
  input  logic [NUM_SRC-1:0]      i_src_valid,
  input  logic [NUM_SRC*XLEN-1:0] i_src_data,
  output logic                    o_sel_err,
  output logic                    o_rd_wvalid,
  output logic [4:0]              o_rd_waddr,
  output logic [XLEN-1:0]         o_rd_wdata
`ifdef WB_ARBITER_BYPASS_EN
  ,
  output logic                    o_byp_valid,
  output logic [4:0]              o_byp_waddr,
  output logic [XLEN-1:0]         o_byp_wdata
`endif
);

  localparam int HEAD = PIPE_DEPTH - 1;

  // Per-stage entry state; index HEAD is the oldest entry.
  logic               valid_reg [PIPE_DEPTH];
  logic [NUM_SRC-1:0] sel_reg   [PIPE_DEPTH];
  logic [4:0]         waddr_reg [PIPE_DEPTH];

  logic               head_valid;
  logic [NUM_SRC-1:0] head_sel;
  logic [4:0]         head_waddr;
  logic               sel_any;
  logic               sel_onehot;
  logic               sel_multi;
  logic               src_ready;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    masked_data [NUM_SRC];

  logic               wr_next;
  logic               err_next;
  logic [4:0]         rd_waddr_next;
  logic [XLEN-1:0]    rd_wdata_next;

  assign head_valid = valid_reg[HEAD];
  assign head_sel   = sel_reg[HEAD];
  assign head_waddr = waddr_reg[HEAD];

  // x & (x-1) clears the lowest set bit, so a non-zero x is one-hot exactly
  // when the result is zero.
  assign sel_any    = |head_sel;
  assign sel_onehot = sel_any && ((head_sel & (head_sel - NUM_SRC'(1))) == '0);
  assign sel_multi  = sel_any && !sel_onehot;

  // Only the selected source's valid matters; with a one-hot select this
  // masked OR is exactly that source's valid bit.
  assign src_ready  = |(head_sel & i_src_valid);

  // Mask every source with its select bit, then OR them together.  With a
  // one-hot select this yields the selected source's data and nothing else.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_mask
      assign masked_data[gi] = head_sel[gi] ? i_src_data[gi*XLEN +: XLEN] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data = sel_data | masked_data[k];
    end
  end

  // Stall only for a well-formed entry whose source is not ready yet.
  // Empty and multi-hot selects retire without waiting.
  assign o_stall = head_valid && sel_onehot && !src_ready;

  // Writes to x0 are dropped, but the entry still retires on the same edge.
  assign wr_next  = head_valid && sel_onehot && src_ready && (head_waddr != 5'd0);
  assign err_next = head_valid && sel_multi;

  // Index/data hold their last written values when no write occurs.
  assign rd_waddr_next = wr_next ? head_waddr : o_rd_waddr;
  assign rd_wdata_next = wr_next ? sel_data   : o_rd_wdata;

  // Stage shift register: advance every stage when not stalled, otherwise
  // freeze everything (including ignoring the issue port).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        valid_reg[s] <= 1'b0;
        sel_reg[s]   <= '0;
        waddr_reg[s] <= '0;
      end
    end else if (!o_stall) begin
      valid_reg[0] <= i_issue_valid;
      sel_reg[0]   <= i_issue_sel;
      waddr_reg[0] <= i_issue_waddr;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        sel_reg[s]   <= sel_reg[s-1];
        waddr_reg[s] <= waddr_reg[s-1];
      end
    end
  end

  // Registered writeback port and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd_wvalid <= 1'b0;
      o_rd_waddr  <= '0;
      o_rd_wdata  <= '0;
      o_sel_err   <= 1'b0;
    end else begin
      o_rd_wvalid <= wr_next;
      o_rd_waddr  <= rd_waddr_next;
      o_rd_wdata  <= rd_wdata_next;
      o_sel_err   <= err_next;
    end
  end

`ifdef WB_ARBITER_BYPASS_EN
  // Forwarding preview: exactly what o_rd_* will show after the next edge.
  assign o_byp_valid = wr_next;
  assign o_byp_waddr = rd_waddr_next;
  assign o_byp_wdata = rd_wdata_next;
`endif

endmodule
